ifft8_seq: RTL and testbench
============================

# ifft8_seq

Sequential 8-point inverse FFT for complex Q4.11 data: the return path for the datapath's combinational forward FFT. It accepts eight frequency bins serially through a valid/ready handshake and runs a 3-stage radix-2 decimation-in-frequency IFFT on one shared butterfly, with 1/2 scaling per stage. It returns the eight time-domain samples serially in natural order. Word format matches the forward FFT: {real[31:16], imag[15:0]}, each half 16-bit two's complement Q4.11 (0x0800 = +1.0).

## Interface
- N, 8: transform length; fixed at 8 (3 stages, 4 butterflies per stage).
- ck  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  32  frequency bin {re, im}; bins arrive in order F0..F7.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a bin; high only in LOAD.
- out_data  output  32  time sample {re, im}; samples leave in order x0..x7.
- out_valid  output  1  out_data valid; high only in UNLOAD.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  high together with out_valid on sample x7.

## Operation
- FSM has three states: LOAD → COMPUTE → UNLOAD → LOAD.
- LOAD
  - in_ready=1.
  - Each in_valid&in_ready beat writes buf[cnt], then cnt++.
  - After the 8th beat, go to COMPUTE with cnt=0.
- COMPUTE
  - One butterfly per cycle; 12 cycles total. Stage s=0,1,2, butterfly b=0..3.
  - Span h = 4>>s.
  - Pair indices: i = (b/h)·2h + (b mod h), j = i+h.
  - Twiddle index k = (b mod h)·2^s.
  - Butterfly on buf[i], buf[j]:
    - buf[i] ← (a+b)>>>1.
    - buf[j] ← mulc((a−b)>>>1, W^-k).
    - Add/sub is 17-bit internally, shifted arithmetically, truncated to 16 bits, per half.
- Twiddle ROM W^-k = {cos, sin} of 2πk/8:
  - k0 = {0x0800, 0x0000}
  - k1 = {0x05A8, 0x05A8}
  - k2 = {0x0000, 0x0800}
  - k3 = {0xFA58, 0x05A8}
- mulc arithmetic:
  - Compute the four signed 16×16 partial products rr, ii, ri, ir.
  - Scale each by 2^-11, truncating toward zero (magnitude bits [26:11], sign re-applied).
  - re = rr − ii; im = ri + ir. Both are mod 2^16, with no saturation.
- UNLOAD
  - out_data = buf[bitrev3(cnt)]; out_valid=1.
  - cnt++ on each out_valid&out_ready beat.
  - After the 8th beat, go to LOAD with cnt=0.
- Total scaling is 1/8, so the output is the true IFFT.
- Overflow wraps silently. Inputs with |re|,|im| < 8.0 cannot overflow.

## Timing
- Reset
  - Enters LOAD with cnt=0 and the stage/butterfly counters at 0.
  - Output values after reset: in_ready=1, out_valid=0, out_last=0, out_data=0.
  - buf is not cleared.
- Reset mid-frame, in any state, has the same effect: the partial frame is discarded and the next accepted beat is F0.
- Latency
  - The 8th input beat is accepted on edge E.
  - Butterflies commit on edges E+1..E+12.
  - out_valid is high from edge E+12 onward.
  - Last input beat to first output is 12 cycles.
- Throughput: one frame per 8+12+8 = 28 cycles at minimum, with no overlap between frames.
- Handshake rules
  - in_valid is ignored outside LOAD.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - After the 8th output beat, in_ready=1 on the next cycle.
- No bypass: inputs never appear combinationally on outputs.

## Structure
- Shared package ifft_pkg holds:
  - the Q4.11 width constants (W_HALF=16, FRAC=11);
  - the twiddle ROM constants;
  - complex add/sub/mulc functions with the truncation rules above, so the forward and inverse paths share arithmetic.
- One sub-module, ifft_bfly: combinational DIF butterfly with 1/2 scaling, taking (a, b, k) and returning (a', b').
- The top level holds the FSM, counters, 8×32 register file and bit-reverse read mux.

## Test plan
- Impulse at bin 0 (F0={0x0800,0}, others 0) → all x0..x7 = {0x0100,0x0000}; out_valid exactly 12 cycles after the 8th input beat.
- All bins {0x0800,0} → x0={0x0800,0x0000}, x1..x7={0x0000,0x0000}.
- Impulse at bin 1 → outputs match a bit-accurate model of the rules above, within ±1 LSB of 0x0100·e^{j2πn/8}: x1≈{0x00B5,0x00B5}, x2={0x0000,0x0100}.
- Backpressure: out_ready toggles randomly → out_data/out_last stay stable while stalled; all 8 samples delivered in order; out_last only on x7.
- rst asserted during COMPUTE step 5 and then released → in_ready=1, out_valid=0 the next cycle; a fresh frame then produces the correct result.
- Round trip: random bins with |re|,|im|<2.0 passed through the forward FFT model → IFFT output within ±4 LSB of the original samples per half.

Source files
------------

// File: rtl/ifft_pkg.sv
// Shared Q4.11 complex arithmetic for the forward and inverse FFT datapaths.
// Words are {re[31:16], im[15:0]}, each half 16-bit two's complement with 11 fractional bits.
package ifft_pkg;

   localparam int W_HALF = 16;
   localparam int FRAC   = 11;
   localparam int N_PTS  = 8;

   typedef logic signed [W_HALF-1:0] half_t;

   typedef struct packed {
      half_t re;
      half_t im;
   } cplx_t;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_COMPUTE,
      ST_UNLOAD
   } state_t;

   // Inverse twiddles W^-k = cos(2*pi*k/8) + j*sin(2*pi*k/8).
   localparam cplx_t TW_K0 = '{re: 16'sh0800, im: 16'sh0000};
   localparam cplx_t TW_K1 = '{re: 16'sh05A8, im: 16'sh05A8};
   localparam cplx_t TW_K2 = '{re: 16'sh0000, im: 16'sh0800};
   localparam cplx_t TW_K3 = '{re: 16'shFA58, im: 16'sh05A8};

   function automatic cplx_t tw_rom(input logic [1:0] k);
      cplx_t w;
      case (k)
         2'd0:    w = TW_K0;
         2'd1:    w = TW_K1;
         2'd2:    w = TW_K2;
         default: w = TW_K3;
      endcase
      return w;
   endfunction

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

   function automatic half_t half_add(input half_t a, input half_t b);
      return a + b;
   endfunction

   function automatic half_t half_sub(input half_t a, input half_t b);
      return a - b;
   endfunction

   // Sum/difference kept at 17 bits so the halving shift never loses the carry.
   function automatic half_t half_add_scaled(input half_t a, input half_t b);
      logic [W_HALF:0] s;
      s = {a[W_HALF-1], a} + {b[W_HALF-1], b};
      return s[W_HALF:1];
   endfunction

   function automatic half_t half_sub_scaled(input half_t a, input half_t b);
      logic [W_HALF:0] s;
      s = {a[W_HALF-1], a} - {b[W_HALF-1], b};
      return s[W_HALF:1];
   endfunction

   // Q4.11 product, truncated toward zero: magnitude bits [26:11] with the sign re-applied.
   function automatic half_t mul_q(input half_t a, input half_t b);
      logic signed [31:0] p;
      logic [31:0]        mag;
      logic [W_HALF-1:0]  m;
      p   = 32'(a) * 32'(b);
      mag = p[31] ? 32'(-p) : 32'(p);
      m   = mag[FRAC+W_HALF-1:FRAC];
      return p[31] ? half_t'(-m) : half_t'(m);
   endfunction

   function automatic cplx_t cplx_add(input cplx_t a, input cplx_t b);
      cplx_t r;
      r.re = half_add(a.re, b.re);
      r.im = half_add(a.im, b.im);
      return r;
   endfunction

   function automatic cplx_t cplx_sub(input cplx_t a, input cplx_t b);
      cplx_t r;
      r.re = half_sub(a.re, b.re);
      r.im = half_sub(a.im, b.im);
      return r;
   endfunction

   function automatic cplx_t cplx_add_scaled(input cplx_t a, input cplx_t b);
      cplx_t r;
      r.re = half_add_scaled(a.re, b.re);
      r.im = half_add_scaled(a.im, b.im);
      return r;
   endfunction

   function automatic cplx_t cplx_sub_scaled(input cplx_t a, input cplx_t b);
      cplx_t r;
      r.re = half_sub_scaled(a.re, b.re);
      r.im = half_sub_scaled(a.im, b.im);
      return r;
   endfunction

   // Partial products are truncated individually before combining; results wrap mod 2^16.
   function automatic cplx_t cplx_mulc(input cplx_t a, input cplx_t w);
      cplx_t r;
      r.re = mul_q(a.re, w.re) - mul_q(a.im, w.im);
      r.im = mul_q(a.re, w.im) + mul_q(a.im, w.re);
      return r;
   endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 DIF butterfly with 1/2 scaling and inverse twiddle on the lower leg.
module ifft_bfly
   import ifft_pkg::*;
(
   input  cplx_t      a,
   input  cplx_t      b,
   input  logic [1:0] k,
   output cplx_t      a_out,
   output cplx_t      b_out
);

   assign a_out = cplx_add_scaled(a, b);
   assign b_out = cplx_mulc(cplx_sub_scaled(a, b), tw_rom(k));

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point IFFT: serial load, 12 in-place butterflies on one shared unit,
// then serial unload through a bit-reverse read mux.
module ifft8_seq
   import ifft_pkg::*;
(
   input  logic        ck,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last
);

   state_t     state;
   logic [2:0] cnt;
   logic [1:0] stage;
   logic [1:0] bfly;
   cplx_t      mem [N_PTS];

   logic [2:0] idx_i;
   logic [2:0] idx_j;
   logic [1:0] tw_k;
   cplx_t      bf_a;
   cplx_t      bf_b;

   // Pair addressing for span h = 4 >> stage: i = (b/h)*2h + b%h, j = i + h, k = (b%h) << stage.
   always_comb begin
      idx_i = 3'd0;
      idx_j = 3'd0;
      tw_k  = 2'd0;
      case (stage)
         2'd0: begin
            idx_i = {1'b0, bfly};
            idx_j = idx_i + 3'd4;
            tw_k  = bfly;
         end
         2'd1: begin
            idx_i = {bfly[1], 1'b0, bfly[0]};
            idx_j = idx_i + 3'd2;
            tw_k  = {bfly[0], 1'b0};
         end
         default: begin
            idx_i = {bfly, 1'b0};
            idx_j = idx_i + 3'd1;
            tw_k  = 2'd0;
         end
      endcase
   end

   ifft_bfly u_bfly (
      .a     (mem[idx_i]),
      .b     (mem[idx_j]),
      .k     (tw_k),
      .a_out (bf_a),
      .b_out (bf_b)
   );

   always_ff @(posedge ck) begin
      if (rst) begin
         state     <= ST_LOAD;
         cnt       <= 3'd0;
         stage     <= 2'd0;
         bfly      <= 2'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid && in_ready) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     state    <= ST_COMPUTE;
                     in_ready <= 1'b0;
                     cnt      <= 3'd0;
                  end
               end
            end
            ST_COMPUTE: begin
               bfly <= bfly + 2'd1;
               if (bfly == 2'd3) begin
                  if (stage == 2'd2) begin
                     stage     <= 2'd0;
                     state     <= ST_UNLOAD;
                     out_valid <= 1'b1;
                  end else begin
                     stage <= stage + 2'd1;
                  end
               end
            end
            ST_UNLOAD: begin
               if (out_ready) begin
                  cnt      <= cnt + 3'd1;
                  out_last <= (cnt == 3'd6);
                  if (cnt == 3'd7) begin
                     state     <= ST_LOAD;
                     cnt       <= 3'd0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     in_ready  <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= ST_LOAD;
               cnt       <= 3'd0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

   // The sample buffer is intentionally left uncleared by reset; only control state restarts.
   always_ff @(posedge ck) begin
      if (!rst) begin
         if (state == ST_LOAD && in_valid && in_ready) begin
            mem[cnt] <= cplx_t'(in_data);
         end else if (state == ST_COMPUTE) begin
            mem[idx_i] <= bf_a;
            mem[idx_j] <= bf_b;
         end
      end
   end

   assign out_data = out_valid ? 32'(mem[bitrev3(cnt)]) : 32'd0;

endmodule

// File: tb/tb_ifft8_seq.sv
// Self-checking bench for ifft8_seq: fixed vectors, random frames against an array-based
// IFFT model, backpressure, mid-compute reset and a forward/inverse round trip.
module tb_ifft8_seq;

   logic        ck = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_beat_cyc = 0;

   logic [31:0] stim [8];
   logic [31:0] expv [8];
   logic [31:0] got  [8];

   int tw_re [4] = '{2048, 1448, 0, -1448};
   int tw_im [4] = '{0, 1448, 2048, 1448};

   typedef struct {
      string       name;
      logic [31:0] fin  [8];
      logic [31:0] fout [8];
   } vec_t;

   vec_t vecs [3];

   ifft8_seq dut (
      .ck        (ck),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   always #5 ck = ~ck;

   always @(posedge ck) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int wrap16(input int v);
      logic [31:0] t;
      t = v;
      return int'($signed(t[15:0]));
   endfunction

   function automatic logic [31:0] pack2(input int re, input int im);
      logic [31:0] r;
      logic [31:0] i;
      r = re;
      i = im;
      return {r[15:0], i[15:0]};
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
      int dr;
      int di;
      dr = int'($signed(act[31:16])) - int'($signed(exp[31:16]));
      di = int'($signed(act[15:0])) - int'($signed(exp[15:0]));
      if (dr < 0) dr = -dr;
      if (di < 0) di = -di;
      total++;
      if (dr > tol || di > tol) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic reportTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: got timeout want event", name);
   endtask

   // Straight textbook DIF IFFT over integer arrays, then natural-order readout.
   task automatic refModel();
      int re [8];
      int im [8];
      for (int n = 0; n < 8; n++) begin
         re[n] = int'($signed(stim[n][31:16]));
         im[n] = int'($signed(stim[n][15:0]));
      end
      for (int s = 0; s < 3; s++) begin
         int h;
         h = 4 >> s;
         for (int b = 0; b < 4; b++) begin
            int i, j, k, ar, ai, br, bi, dr, di;
            i  = (b / h) * 2 * h + (b % h);
            j  = i + h;
            k  = (b % h) * (1 << s);
            ar = re[i]; ai = im[i]; br = re[j]; bi = im[j];
            re[i] = wrap16((ar + br) >>> 1);
            im[i] = wrap16((ai + bi) >>> 1);
            dr = wrap16((ar - br) >>> 1);
            di = wrap16((ai - bi) >>> 1);
            re[j] = wrap16(dr * tw_re[k] / 2048 - di * tw_im[k] / 2048);
            im[j] = wrap16(dr * tw_im[k] / 2048 + di * tw_re[k] / 2048);
         end
      end
      for (int n = 0; n < 8; n++) begin
         int r;
         r = ((n & 1) << 2) | (n & 2) | (n >> 2);
         expv[n] = pack2(re[r], im[r]);
      end
   endtask

   task automatic applyStimulus();
      for (int n = 0; n < 8; n++) begin
         int guard;
         in_data  = stim[n];
         in_valid = 1'b1;
         guard = 0;
         while (!in_ready && guard < 200) begin
            @(posedge ck); #1;
            guard++;
         end
         if (!in_ready) reportTimeout("in_ready_wait");
         @(posedge ck); #1;
      end
      last_beat_cyc = cyc;
      in_valid = 1'b1;
      in_data  = $urandom;
   endtask

   task automatic collectOutput(input bit bp);
      int guard;
      guard = 0;
      while (!out_valid && guard < 100) begin
         @(posedge ck); #1;
         guard++;
      end
      if (!out_valid) begin
         reportTimeout("out_valid_wait");
         in_valid = 1'b0;
         return;
      end
      checkVal("latency", 32'(cyc - last_beat_cyc), 32'd12, 0);
      for (int n = 0; n < 8; n++) begin
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         guard = 0;
         while (!out_ready) begin
            logic [31:0] hd;
            logic        hl;
            hd = out_data;
            hl = out_last;
            @(posedge ck); #1;
            checkVal("stall_data", out_data, hd, 0);
            checkVal("stall_last", {31'd0, out_last}, {31'd0, hl}, 0);
            checkVal("stall_valid", {31'd0, out_valid}, 32'd1, 0);
            guard++;
            out_ready = (guard > 20) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         checkVal("beat_valid", {31'd0, out_valid}, 32'd1, 0);
         checkVal($sformatf("last_x%0d", n), {31'd0, out_last}, {31'd0, n == 7}, 0);
         got[n] = out_data;
         @(posedge ck); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkVal("ready_after", {31'd0, in_ready}, 32'd1, 0);
      checkVal("valid_after", {31'd0, out_valid}, 32'd0, 0);
   endtask

   task automatic checkOutput(input string name, input int tol);
      for (int n = 0; n < 8; n++) begin
         checkVal($sformatf("%s_x%0d", name, n), got[n], expv[n], tol);
      end
   endtask

   initial begin
      vecs[0].name = "impulse_f0";
      vecs[1].name = "all_ones";
      vecs[2].name = "impulse_f1";
      for (int n = 0; n < 8; n++) begin
         vecs[0].fin[n]  = (n == 0) ? 32'h0800_0000 : 32'd0;
         vecs[0].fout[n] = 32'h0100_0000;
         vecs[1].fin[n]  = 32'h0800_0000;
         vecs[1].fout[n] = (n == 0) ? 32'h0800_0000 : 32'd0;
         vecs[2].fin[n]  = (n == 1) ? 32'h0800_0000 : 32'd0;
      end
      vecs[2].fout = '{32'h0100_0000, 32'h00B5_00B5, 32'h0000_0100, 32'hFF4B_00B5,
                       32'hFF00_0000, 32'hFF4B_FF4B, 32'h0000_FF00, 32'h00B5_FF4B};

      rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      rst = 1'b0;
      checkVal("rst_in_ready", {31'd0, in_ready}, 32'd1, 0);
      checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
      checkVal("rst_out_last", {31'd0, out_last}, 32'd0, 0);
      checkVal("rst_out_data", out_data, 32'd0, 0);

      for (int v = 0; v < 3; v++) begin
         for (int n = 0; n < 8; n++) begin
            stim[n] = vecs[v].fin[n];
            expv[n] = vecs[v].fout[n];
         end
         applyStimulus();
         collectOutput(v == 2);
         checkOutput(vecs[v].name, 0);
      end

      for (int r = 0; r < 6; r++) begin
         for (int n = 0; n < 8; n++) stim[n] = $urandom;
         refModel();
         applyStimulus();
         collectOutput(r[0]);
         checkOutput($sformatf("rand%0d", r), 0);
      end

      for (int n = 0; n < 8; n++) stim[n] = $urandom;
      applyStimulus();
      in_valid = 1'b0;
      repeat (4) @(posedge ck);
      #1;
      rst = 1'b1;
      @(posedge ck); #1;
      rst = 1'b0;
      checkVal("midrst_in_ready", {31'd0, in_ready}, 32'd1, 0);
      checkVal("midrst_out_valid", {31'd0, out_valid}, 32'd0, 0);
      repeat (12) @(posedge ck);
      #1;
      checkVal("midrst_idle_valid", {31'd0, out_valid}, 32'd0, 0);
      checkVal("midrst_idle_ready", {31'd0, in_ready}, 32'd1, 0);
      for (int n = 0; n < 8; n++) begin
         stim[n] = vecs[2].fin[n];
         expv[n] = vecs[2].fout[n];
      end
      applyStimulus();
      collectOutput(1'b0);
      checkOutput("after_rst", 0);

      for (int t = 0; t < 3; t++) begin
         int xr [8];
         int xi [8];
         for (int n = 0; n < 8; n++) begin
            xr[n] = int'($urandom_range(0, 510)) - 255;
            xi[n] = int'($urandom_range(0, 510)) - 255;
            expv[n] = pack2(xr[n], xi[n]);
         end
         for (int k = 0; k < 8; k++) begin
            real sr, si, ang;
            sr = 0.0; si = 0.0;
            for (int n = 0; n < 8; n++) begin
               ang = 2.0 * 3.141592653589793 * real'(k * n) / 8.0;
               sr = sr + real'(xr[n]) * $cos(ang) + real'(xi[n]) * $sin(ang);
               si = si + real'(xi[n]) * $cos(ang) - real'(xr[n]) * $sin(ang);
            end
            stim[k] = pack2($rtoi(sr + ((sr >= 0.0) ? 0.5 : -0.5)),
                            $rtoi(si + ((si >= 0.0) ? 0.5 : -0.5)));
         end
         applyStimulus();
         collectOutput(1'b1);
         checkOutput($sformatf("roundtrip%0d", t), 4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
